// File: rtl/vga_sprite_mixer_pkg.sv
// vga_sprite_mixer_pkg: shared sprite attribute type and pixel widths.
package vga_sprite_mixer_pkg;
  localparam int RGB_W = 16;
  localparam int PAT_W = 2;
  localparam int COORD_W = 10;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 16'hF81F;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [PAT_W-1:0]   pat;
    logic               vis;
  } sprite_attr_t;
endpackage

// File: rtl/sprite_rom.sv
// sprite_rom: combinational 4-pattern RGB565 sprite lookup indexed by (pat, dy, dx).
module sprite_rom
  import vga_sprite_mixer_pkg::*;
#(
  parameter int SPRITE_SIZE = 16,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
  localparam int OW = $clog2(SPRITE_SIZE)
) (
  input  logic [PAT_W-1:0] pat,
  input  logic [OW-1:0]    dx,
  input  logic [OW-1:0]    dy,
  output logic [RGB_W-1:0] rgb
);
  // 0: solid blue, 1: red with transparent diagonal, 2: green/transparent checker, 3: gradient
  always_comb
    rgb = pat == 2'd0 ? 16'h001F :
          pat == 2'd1 ? (dx == dy ? KEY_COLOR : 16'hF800) :
          pat == 2'd2 ? ((dx[0] ^ dy[0]) ? KEY_COLOR : 16'h07E0) :
          16'h2000 | RGB_W'({dy, dx});
endmodule

// File: rtl/vga_sprite_mixer.sv
// vga_sprite_mixer: 2-stage sprite compositor over a solid/checkerboard background.
module vga_sprite_mixer
  import vga_sprite_mixer_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 16,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
  parameter logic [RGB_W-1:0] BG_A = 16'h0000,
  parameter logic [RGB_W-1:0] BG_B = 16'hFFFF,
  localparam int SEL_W = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1,
  localparam int OW = $clog2(SPRITE_SIZE)
) (
  input  logic               iVGA_CLK,
  input  logic               iReset,
  input  logic [9:0]         ivga_x,
  input  logic [9:0]         ivga_y,
  input  logic               iValid,
  input  logic               iFrame_start,
  input  logic               iColor_SW,
  input  logic               iWr_en,
  input  logic [SEL_W-1:0]   iWr_sel,
  input  logic [9:0]         iWr_x,
  input  logic [9:0]         iWr_y,
  input  logic [PAT_W-1:0]   iWr_pat,
  input  logic               iWr_vis,
  output logic [RGB_W-1:0]   oRGB,
  output logic               oValid,
  output logic               oCollision
);
  sprite_attr_t shadow [NUM_SPRITES];
  sprite_attr_t active [NUM_SPRITES];
  sprite_attr_t wr_attr;
  logic [NUM_SPRITES-1:0] wr_hit;
  always_comb begin
    wr_attr = '{x: iWr_x, y: iWr_y, pat: iWr_pat, vis: iWr_vis};
    for (int i = 0; i < NUM_SPRITES; i++) wr_hit[i] = iWr_en && iWr_sel == SEL_W'(i);
  end
  // a write coinciding with the frame pulse lands in the active set directly
  always_ff @(posedge iVGA_CLK)
    for (int i = 0; i < NUM_SPRITES; i++)
      if (iReset) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end else begin
        if (wr_hit[i]) shadow[i] <= wr_attr;
        if (iFrame_start) active[i] <= wr_hit[i] ? wr_attr : shadow[i];
      end
  logic [9:0] ox [NUM_SPRITES];
  logic [9:0] oy [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] hit;
  // x >= sx guarantees a non-negative offset, so no wrap past column 1023
  always_comb
    for (int i = 0; i < NUM_SPRITES; i++) begin
      ox[i] = ivga_x - active[i].x;
      oy[i] = ivga_y - active[i].y;
      hit[i] = active[i].vis && ivga_x >= active[i].x && ivga_y >= active[i].y &&
               ox[i] < 10'(SPRITE_SIZE) && oy[i] < 10'(SPRITE_SIZE);
    end
  logic                   s1_valid;
  logic [NUM_SPRITES-1:0] s1_hit;
  logic [RGB_W-1:0]       s1_bg;
  logic [OW-1:0]          s1_dx  [NUM_SPRITES];
  logic [OW-1:0]          s1_dy  [NUM_SPRITES];
  logic [PAT_W-1:0]       s1_pat [NUM_SPRITES];
  always_ff @(posedge iVGA_CLK)
    if (iReset) begin
      s1_valid <= 1'b0;
      s1_hit <= '0;
      s1_bg <= '0;
    end else begin
      s1_valid <= iValid;
      s1_hit <= hit;
      s1_bg <= (iColor_SW && (ivga_x[4] ^ ivga_y[4])) ? BG_B : BG_A;
    end
  always_ff @(posedge iVGA_CLK)
    for (int i = 0; i < NUM_SPRITES; i++) begin
      s1_dx[i] <= ox[i][OW-1:0];
      s1_dy[i] <= oy[i][OW-1:0];
      s1_pat[i] <= active[i].pat;
    end
  logic [RGB_W-1:0]       rom [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] opaque;
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_rom
    sprite_rom #(.SPRITE_SIZE(SPRITE_SIZE), .KEY_COLOR(KEY_COLOR)) u_rom (
      .pat(s1_pat[g]),
      .dx (s1_dx[g]),
      .dy (s1_dy[g]),
      .rgb(rom[g])
    );
    assign opaque[g] = s1_hit[g] && rom[g] != KEY_COLOR;
  end
  logic [RGB_W-1:0] pix;
  logic seen, multi, coll_now, coll_flag;
  always_comb begin
    pix = s1_bg;
    seen = 1'b0;
    multi = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      pix = opaque[i] ? rom[i] : pix;
      multi = multi | (seen & opaque[i]);
      seen = seen | opaque[i];
    end
    coll_now = s1_valid && multi;
  end
  always_ff @(posedge iVGA_CLK)
    if (iReset) begin
      oRGB <= '0;
      oValid <= 1'b0;
      oCollision <= 1'b0;
      coll_flag <= 1'b0;
    end else begin
      oRGB <= s1_valid ? pix : '0;
      oValid <= s1_valid;
      oCollision <= iFrame_start ? (coll_flag || coll_now) : oCollision;
      coll_flag <= !iFrame_start && (coll_flag || coll_now);
    end
endmodule

// File: tb/tb_vga_sprite_mixer.sv
// tb_vga_sprite_mixer: table-driven pixel checks through a latency-2 scoreboard plus frame/collision sequences.
module tb_vga_sprite_mixer;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] ivga_x, ivga_y, wr_x, wr_y;
  logic valid, frame, color_sw, wr_en, wr_vis;
  logic [1:0] wr_sel, wr_pat;
  logic [15:0] rgb;
  logic o_valid, o_coll;
  always #5 clk = ~clk;
  vga_sprite_mixer dut (
    .iVGA_CLK(clk), .iReset(rst), .ivga_x(ivga_x), .ivga_y(ivga_y), .iValid(valid),
    .iFrame_start(frame), .iColor_SW(color_sw), .iWr_en(wr_en), .iWr_sel(wr_sel),
    .iWr_x(wr_x), .iWr_y(wr_y), .iWr_pat(wr_pat), .iWr_vis(wr_vis),
    .oRGB(rgb), .oValid(o_valid), .oCollision(o_coll)
  );
  typedef struct { logic [15:0] rgb; int due; string nm; } exp_t;
  typedef struct { logic [9:0] x; logic [9:0] y; logic sw; logic [15:0] rgb; string nm; } vec_t;
  exp_t q[$];
  vec_t tbl [14];
  int checks = 0, failures = 0, cyc = 0;
  logic quiet = 1'b0;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (q.size() != 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (o_valid !== 1'b1 || rgb !== e.rgb) begin
        failures++;
        $display("FAIL %s rgb=%h valid=%b want rgb=%h valid=1", e.nm, rgb, o_valid, e.rgb);
      end
    end else if (!quiet) begin
      checks++;
      if (o_valid !== 1'b0 || rgb !== 16'h0000) begin
        failures++;
        $display("FAIL idle@%0d rgb=%h valid=%b want rgb=0000 valid=0", cyc, rgb, o_valid);
      end
    end
  end
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    valid = 0; frame = 0; wr_en = 0;
  endtask
  task automatic pulse_frame();
    @(negedge clk);
    valid = 0; frame = 1; wr_en = 0;
  endtask
  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic sw, input logic [15:0] want, input string nm);
    @(negedge clk);
    ivga_x = x; ivga_y = y; color_sw = sw; valid = 1; frame = 0; wr_en = 0;
    q.push_back('{want, cyc + 2, nm});
  endtask
  task automatic wr(input logic [1:0] sel, input logic [9:0] x, input logic [9:0] y,
                    input logic [1:0] pat, input logic vis, input logic fs);
    @(negedge clk);
    valid = 0; frame = fs; wr_en = 1;
    wr_sel = sel; wr_x = x; wr_y = y; wr_pat = pat; wr_vis = vis;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0]  = '{10'd0,   10'd0,   1'b1, 16'h0000, "bg_0_0"};
    tbl[1]  = '{10'd16,  10'd0,   1'b1, 16'hFFFF, "bg_16_0"};
    tbl[2]  = '{10'd16,  10'd16,  1'b1, 16'h0000, "bg_16_16"};
    tbl[3]  = '{10'd16,  10'd0,   1'b0, 16'h0000, "bg_solid"};
    tbl[4]  = '{10'd100, 10'd50,  1'b1, 16'h2000, "s0_origin"};
    tbl[5]  = '{10'd115, 10'd65,  1'b1, 16'h20FF, "s0_corner"};
    tbl[6]  = '{10'd116, 10'd50,  1'b1, 16'h0000, "s0_right_edge"};
    tbl[7]  = '{10'd99,  10'd50,  1'b1, 16'hFFFF, "s0_left_edge"};
    tbl[8]  = '{10'd100, 10'd66,  1'b1, 16'h0000, "s0_bottom_edge"};
    tbl[9]  = '{10'd103, 10'd52,  1'b1, 16'h2023, "s0_inner"};
    tbl[10] = '{10'd200, 10'd200, 1'b1, 16'h07E0, "prio_s1"};
    tbl[11] = '{10'd201, 10'd200, 1'b1, 16'h001F, "key_over_s2"};
    tbl[12] = '{10'd300, 10'd300, 1'b1, 16'h0000, "s3_key_bg"};
    tbl[13] = '{10'd301, 10'd300, 1'b1, 16'hF800, "s3_red"};
    rst = 1; ivga_x = 0; ivga_y = 0; valid = 0; frame = 0; color_sw = 1;
    wr_en = 0; wr_sel = 0; wr_x = 0; wr_y = 0; wr_pat = 0; wr_vis = 0;
    wr(2'd0, 10'd0, 10'd0, 2'd0, 1'b1, 1'b1);
    idle();
    idle();
    chk("rst_coll", {15'b0, o_coll}, 16'h0);
    rst = 0;
    pulse_frame();
    px(10'd0, 10'd0, 1'b1, 16'h0000, "rst_dominates_wr");
    wr(2'd0, 10'd100, 10'd50, 2'd3, 1'b1, 1'b0);
    wr(2'd1, 10'd200, 10'd200, 2'd2, 1'b1, 1'b0);
    wr(2'd2, 10'd200, 10'd200, 2'd0, 1'b1, 1'b0);
    wr(2'd3, 10'd300, 10'd300, 2'd1, 1'b1, 1'b0);
    px(10'd100, 10'd50, 1'b1, 16'hFFFF, "shadow_not_active");
    pulse_frame();
    for (int i = 0; i < 14; i++) px(tbl[i].x, tbl[i].y, tbl[i].sw, tbl[i].rgb, tbl[i].nm);
    repeat (3) idle();
    pulse_frame();
    idle();
    chk("coll_set", {15'b0, o_coll}, 16'h1);
    px(10'd201, 10'd200, 1'b1, 16'h001F, "key_no_coll_px");
    repeat (3) idle();
    pulse_frame();
    idle();
    chk("coll_clean_frame", {15'b0, o_coll}, 16'h0);
    px(10'd200, 10'd200, 1'b1, 16'h07E0, "same_cycle_px");
    pulse_frame();
    idle();
    chk("coll_same_cycle", {15'b0, o_coll}, 16'h1);
    pulse_frame();
    idle();
    chk("coll_cleared", {15'b0, o_coll}, 16'h0);
    px(10'd205, 10'd200, 1'b1, 16'h001F, "pre_move");
    wr(2'd2, 10'd1020, 10'd10, 2'd0, 1'b1, 1'b0);
    px(10'd205, 10'd200, 1'b1, 16'h001F, "mid_frame_old");
    px(10'd1020, 10'd10, 1'b1, 16'hFFFF, "mid_frame_new_hidden");
    pulse_frame();
    px(10'd1020, 10'd10, 1'b1, 16'h001F, "edge_1020");
    px(10'd1023, 10'd10, 1'b1, 16'h001F, "edge_1023");
    px(10'd1019, 10'd10, 1'b1, 16'hFFFF, "edge_1019");
    px(10'd0, 10'd10, 1'b1, 16'h0000, "nowrap_0");
    px(10'd11, 10'd10, 1'b1, 16'h0000, "nowrap_11");
    px(10'd205, 10'd200, 1'b1, 16'h0000, "moved_away");
    wr(2'd3, 10'd300, 10'd300, 2'd1, 1'b0, 1'b1);
    px(10'd301, 10'd300, 1'b1, 16'h0000, "wr_with_frame");
    repeat (3) idle();
    quiet = 1;
    @(negedge clk);
    ivga_x = 10'd1020; ivga_y = 10'd10; valid = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_valid", {15'b0, o_valid}, 16'h0);
    chk("rst_mid_rgb", rgb, 16'h0000);
    rst = 0;
    valid = 0;
    repeat (3) idle();
    quiet = 0;
    chk("rst_mid_coll", {15'b0, o_coll}, 16'h0);
    pulse_frame();
    px(10'd1020, 10'd10, 1'b1, 16'hFFFF, "post_rst_s2_gone");
    px(10'd100, 10'd50, 1'b1, 16'hFFFF, "post_rst_s0_gone");
    repeat (4) idle();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
